// File: rtl/hilo_md_sequencer_pkg.sv
// Shared HI/LO opcode encodings and helpers for the E-stage multiply/divide unit.
package hilo_md_sequencer_pkg;

    localparam logic [3:0] HILO_MULT  = 4'd0;
    localparam logic [3:0] HILO_MULTU = 4'd1;
    localparam logic [3:0] HILO_DIV   = 4'd2;
    localparam logic [3:0] HILO_DIVU  = 4'd3;
    localparam logic [3:0] HILO_MTHI  = 4'd4;
    localparam logic [3:0] HILO_MTLO  = 4'd5;
    localparam logic [3:0] HILO_MFHI  = 4'd6;
    localparam logic [3:0] HILO_MFLO  = 4'd7;
    localparam logic [3:0] HILO_NONE  = 4'b1000;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU) || (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage

// File: rtl/hilo_md_sequencer_md_calc.sv
// Combinational mult/multu/div/divu datapath producing the {HI,LO} result pair.
module hilo_md_sequencer_md_calc
    import hilo_md_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic [63:0] prod;
    logic [31:0] b_safe;

    // Divisor forced non-zero so the divider never produces X; div0 suppresses the commit.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign div0   = is_div_op(op) && (b == 32'd0);

    always_comb begin
        prod = '0;
        hi   = '0;
        lo   = '0;
        case (op)
            HILO_MULT: begin
                prod = 64'($signed(a)) * 64'($signed(b));
                {hi, lo} = prod;
            end
            HILO_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                {hi, lo} = prod;
            end
            HILO_DIV: begin
                lo = 32'($signed(a) / $signed(b_safe));
                hi = 32'($signed(a) % $signed(b_safe));
            end
            HILO_DIVU: begin
                lo = a / b_safe;
                hi = a % b_safe;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_md_sequencer.sv
// E-stage multi-cycle multiply/divide sequencer with HI/LO registers and D-stage stall request.
module hilo_md_sequencer
    import hilo_md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  HILOOp_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        md_D,
    input  logic        mf_D,
    input  logic        mt_D,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HILO_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic [31:0]       calc_hi, calc_lo;
    logic              calc_div0;

    hilo_md_sequencer_md_calc u_md_calc (
        .op   (HILOOp_E),
        .a    (A_E),
        .b    (B_E),
        .hi   (calc_hi),
        .lo   (calc_lo),
        .div0 (calc_div0)
    );

    assign busy     = (state_q == StBusy);
    assign start    = is_md_op(HILOOp_E) && (state_q == StIdle);
    assign stall_md = (start | busy) & (md_D | mf_D | mt_D);

    always_comb begin
        HILO_out = '0;
        if (HILOOp_E == HILO_MFHI) begin
            HILO_out = hi_q;
        end else if (HILOOp_E == HILO_MFLO) begin
            HILO_out = lo_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    // Divide by zero re-latches current HI/LO so the commit is a no-op.
                    tmp_hi_d = calc_div0 ? hi_q : calc_hi;
                    tmp_lo_d = calc_div0 ? lo_q : calc_lo;
                    cnt_d    = is_div_op(HILOOp_E) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    state_d  = StBusy;
                end else if (HILOOp_E == HILO_MTHI) begin
                    hi_d = A_E;
                end else if (HILOOp_E == HILO_MTLO) begin
                    lo_d = A_E;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed bench for hilo_md_sequencer: latency, arithmetic, div-by-zero, stall and reset abort.
module tb_hilo_md_sequencer;
    import hilo_md_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  HILOOp_E;
    logic [31:0] A_E, B_E;
    logic        md_D, mf_D, mt_D;
    logic        start, busy, stall_md;
    logic [31:0] HILO_out;

    int checks = 0;
    int errors = 0;

    hilo_md_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .HILOOp_E (HILOOp_E),
        .A_E      (A_E),
        .B_E      (B_E),
        .md_D     (md_D),
        .mf_D     (mf_D),
        .mt_D     (mt_D),
        .start    (start),
        .busy     (busy),
        .stall_md (stall_md),
        .HILO_out (HILO_out)
    );

    always #5 clk = ~clk;

    // Drive in the low phase and settle; sampling happens well before the next rising edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mf);
        @(negedge clk);
        HILOOp_E = op;
        A_E      = a;
        B_E      = b;
        md_D     = 1'b0;
        mf_D     = mf;
        mt_D     = 1'b0;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(HILO_MFHI, 32'd0, 32'd0, 1'b0);
        chk({tag, "_hi"}, HILO_out, hi);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        drive(HILO_MFLO, 32'd0, 32'd0, 1'b0);
        chk({tag, "_lo"}, HILO_out, lo);
    endtask

    // Start an md op and check start plus the exact busy window length.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        drive(op, a, b, 1'b0);
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        chk({tag, "_busy_t0"}, {31'd0, busy}, 32'd0);
        for (int i = 1; i <= n; i++) begin
            drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
            chk($sformatf("%s_busy_t%0d", tag, i), {30'd0, start, busy}, 32'd1);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        HILOOp_E = HILO_MULT;
        A_E      = 32'd0;
        B_E      = 32'd0;
        md_D     = 1'b0;
        mf_D     = 1'b0;
        mt_D     = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_comb", {31'd0, start}, 32'd1);
        HILOOp_E = HILO_MFHI;
        #1;
        chk("rst_hi", HILO_out, 32'd0);
        chk("rst_start_none", {31'd0, start}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: mult -3 * 7 = -21
        run_md("mult", HILO_MULT, 32'hFFFF_FFFD, 32'd7, 5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // 2: multu with a stray md op during busy that must be ignored
        drive(HILO_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_start", {31'd0, start}, 32'd1);
        drive(HILO_MULT, 32'd3, 32'd3, 1'b0);
        chk("multu_stray_start", {30'd0, start, busy}, 32'd1);
        for (int i = 2; i <= 5; i++) begin
            drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
            chk($sformatf("multu_busy_t%0d", i), {31'd0, busy}, 32'd1);
        end
        read_hilo("multu", 32'd1, 32'hFFFF_FFFE);

        // 3: div -7 / 2 = -3 rem -1
        run_md("div", HILO_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // 4: divu by zero keeps preloaded HI/LO
        drive(HILO_MTHI, 32'd5, 32'd0, 1'b0);
        drive(HILO_MTLO, 32'd9, 32'd0, 1'b0);
        read_hilo("mt", 32'd5, 32'd9);
        run_md("divu0", HILO_DIVU, 32'd7, 32'd0, 10);
        read_hilo("divu0", 32'd5, 32'd9);

        // 5: div 100 / -7 = -14 rem 2 with mflo waiting in D
        drive(HILO_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
        chk("stall_start", {31'd0, stall_md}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            drive(HILO_NONE, 32'd0, 32'd0, 1'b1);
            chk($sformatf("stall_t%0d", i), {31'd0, stall_md}, 32'd1);
        end
        drive(HILO_NONE, 32'd0, 32'd0, 1'b1);
        chk("stall_drop", {31'd0, stall_md}, 32'd0);
        drive(HILO_MFLO, 32'd0, 32'd0, 1'b0);
        chk("stall_mflo", HILO_out, 32'hFFFF_FFF2);
        drive(HILO_MFHI, 32'd0, 32'd0, 1'b0);
        chk("stall_mfhi", HILO_out, 32'd2);

        // 6: reset in busy cycle 3 aborts the mult
        drive(HILO_MULT, 32'd3, 32'd4, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        end
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset_n  = 1'b0;
        HILOOp_E = HILO_MFHI;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HILO_out, 32'd0);
        HILOOp_E = HILO_MFLO;
        #1;
        chk("abort_lo", HILO_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
            chk($sformatf("abort_idle_%0d", i), {31'd0, busy}, 32'd0);
        end
        read_hilo("abort", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
